bank_arbiter: RTL and testbench

BANK_ARBITER -- requirements
Module: bank_arbiter

---
 rtl/bank_arbiter_pkg.sv | 32 +++
 rtl/bank_arbiter_if.sv | 42 ++++
 rtl/bank_arbiter_rr_arbiter.sv | 46 ++++
 rtl/bank_arbiter.sv | 128 ++++++++++++
 tb/tb_bank_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/bank_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bank_arbiter_pkg
// Shared parameters and types for the banked memory arbiter.
//   DEFAULT_REQUESTERS  number of requester ports
//   DEFAULT_BANKS       total banks in the memory system
//   DEFAULT_DATA_WIDTH  data word width
//   DEFAULT_ADDR_WIDTH  global address width
//   DEFAULT_BANK_SIZE   words per bank (address space split evenly over banks)
//   bank_req_t          one requester's access: we, addr, wdata
//   idx_width()         index width for an N-entry vector (at least 1 bit)
// -----------------------------------------------------------------------------
package bank_arbiter_pkg;

   localparam int DEFAULT_REQUESTERS = 6;
   localparam int DEFAULT_BANKS      = 6;
   localparam int DEFAULT_DATA_WIDTH = 17;
   localparam int DEFAULT_ADDR_WIDTH = 17;
   // 2**17 / 6 = 21845 words per bank; the few words above BANKS*BANK_SIZE
   // belong to no bank and are never acknowledged.
   localparam int DEFAULT_BANK_SIZE  = (1 << DEFAULT_ADDR_WIDTH) / DEFAULT_BANKS;

   typedef struct packed {
      logic                          we;
      logic [DEFAULT_ADDR_WIDTH-1:0] addr;
      logic [DEFAULT_DATA_WIDTH-1:0] wdata;
   } bank_req_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bank_arbiter_if.sv
// -----------------------------------------------------------------------------
// bank_arbiter_if
// Requester-side and bank-side signals of one bank arbiter.
//   req_i/we_i/addr_i/wdata_i  per-requester access request (held until acked)
//   ack_o                      one-cycle grant acknowledge per requester
//   rvalid_o/rdata_o           one-hot read-data valid plus shared read data
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i  bank port
// Handshake: a requester raises req_i with its we/addr/wdata and keeps them
// stable until the cycle in which ack_o for it is high; it may then drop req_i
// or present a new access from the following cycle on.
// Modports: slave = arbiter side, master = requesters + memory side.
// -----------------------------------------------------------------------------
interface bank_arbiter_if
   import bank_arbiter_pkg::*;
#(
   parameter int REQUESTERS = DEFAULT_REQUESTERS,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
   logic [REQUESTERS-1:0]                 req_i;
   logic [REQUESTERS-1:0]                 we_i;
   logic [REQUESTERS-1:0][ADDR_WIDTH-1:0] addr_i;
   logic [REQUESTERS-1:0][DATA_WIDTH-1:0] wdata_i;
   logic [REQUESTERS-1:0]                 ack_o;
   logic [REQUESTERS-1:0]                 rvalid_o;
   logic [DATA_WIDTH-1:0]                 rdata_o;
   logic                                  mem_en_o;
   logic                                  mem_we_o;
   logic [ADDR_WIDTH-1:0]                 mem_addr_o;
   logic [DATA_WIDTH-1:0]                 mem_wdata_o;
   logic [DATA_WIDTH-1:0]                 mem_rdata_i;

   modport slave (
      input  req_i, we_i, addr_i, wdata_i, mem_rdata_i,
      output ack_o, rvalid_o, rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

   modport master (
      output req_i, we_i, addr_i, wdata_i, mem_rdata_i,
      input  ack_o, rvalid_o, rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
   );
endinterface

// File: rtl/bank_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first set bit of req found when
// scanning upward from index ptr (wrapping) wins.
//   req          request vector
//   ptr          scan start index (0..N-1)
//   grant        one-hot winner
//   grant_idx    winner index
//   grant_valid  any request present
// -----------------------------------------------------------------------------
module rr_arbiter
   import bank_arbiter_pkg::*;
#(
   parameter  int N     = DEFAULT_REQUESTERS,
   localparam int IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid
);
   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] j;

   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      sum         = '0;
      j           = '0;
      for (int k = 0; k < N; k++) begin
         // one extra bit so ptr + k cannot wrap before the modulo fix-up
         sum = {1'b0, ptr} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(N)) begin
            sum = sum - (IDX_W+1)'(N);
         end
         j = sum[IDX_W-1:0];
         if (!grant_valid && req[j]) begin
            grant_valid = 1'b1;
            grant[j]    = 1'b1;
            grant_idx   = j;
         end
      end
   end
endmodule

// File: rtl/bank_arbiter.sv
// -----------------------------------------------------------------------------
// bank_arbiter
// Arbitrates REQUESTERS ports onto the single port of bank BANK_ID. Only
// requests whose global address falls inside this bank are considered; the
// winner is acked one cycle after the grant together with the bank access,
// and read data returns one cycle later (bank read latency is one cycle).
//   clk, rst       clock, synchronous active-high reset
//   bus            bank_arbiter_if.slave (requester and bank signals)
//   conflict_cnt_o only when BANK_ARBITER_STATS_EN is defined: saturating
//                  count of cycles with two or more eligible requesters
// Build option: `define BANK_ARBITER_STATS_EN to add the conflict counter.
// -----------------------------------------------------------------------------
module bank_arbiter
   import bank_arbiter_pkg::*;
#(
   parameter int REQUESTERS = DEFAULT_REQUESTERS,
   parameter int BANKS      = DEFAULT_BANKS,
   parameter int BANK_ID    = 0,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int BANK_SIZE  = DEFAULT_BANK_SIZE
) (
   input  logic          clk,
   input  logic          rst,
   bank_arbiter_if.slave bus
`ifdef BANK_ARBITER_STATS_EN
   ,
   output logic [31:0]   conflict_cnt_o
`endif
);
   localparam int IDX_W = idx_width(REQUESTERS);

   // Bank window in ADDR_WIDTH+1 bits so the last bank's upper bound fits.
   localparam logic [ADDR_WIDTH:0] BASE  = (ADDR_WIDTH+1)'(BANK_ID * BANK_SIZE);
   localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'((BANK_ID + 1) * BANK_SIZE);
   // An instance configured outside the bank set owns no addresses.
   localparam bit BANK_VALID = (BANK_ID < BANKS);

   logic [IDX_W-1:0]      ptr;
   logic [REQUESTERS-1:0] ack_q;
   logic [REQUESTERS-1:0] rvalid_q;
   logic                  mem_en_q;
   logic                  mem_we_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;

   logic [REQUESTERS-1:0] eligible;
   logic [ADDR_WIDTH:0]   addr_ext;
   logic [REQUESTERS-1:0] grant;
   logic [IDX_W-1:0]      grant_idx;
   logic                  grant_valid;
   logic [IDX_W-1:0]      next_ptr;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   // A requester being acked this cycle is skipped, so its held request is
   // not granted twice; it becomes eligible again on the next cycle.
   always_comb begin
      eligible = '0;
      addr_ext = '0;
      for (int i = 0; i < REQUESTERS; i++) begin
         addr_ext    = {1'b0, bus.addr_i[i]};
         eligible[i] = BANK_VALID && bus.req_i[i] && !ack_q[i] &&
                       (addr_ext >= BASE) && (addr_ext < LIMIT);
      end
   end

   rr_arbiter #(.N(REQUESTERS)) u_rr (
      .req         (eligible),
      .ptr         (ptr),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   assign next_ptr  = (grant_idx == IDX_W'(REQUESTERS - 1)) ? '0 : grant_idx + 1'b1;
   assign sel_we    = bus.we_i[grant_idx];
   assign sel_addr  = bus.addr_i[grant_idx] - BASE[ADDR_WIDTH-1:0];
   assign sel_wdata = bus.wdata_i[grant_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr         <= '0;
         ack_q       <= '0;
         rvalid_q    <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         ack_q       <= grant;
         mem_en_q    <= grant_valid;
         mem_we_q    <= grant_valid & sel_we;
         mem_addr_q  <= grant_valid ? sel_addr  : '0;
         mem_wdata_q <= grant_valid ? sel_wdata : '0;
         // the bank returns data one cycle after a read access; ack_q still
         // names the requester that issued it
         rvalid_q    <= (mem_en_q && !mem_we_q) ? ack_q : '0;
         if (grant_valid) begin
            ptr <= next_ptr;
         end
      end
   end

   assign bus.ack_o       = ack_q;
   assign bus.rvalid_o    = rvalid_q;
   assign bus.rdata_o     = (|rvalid_q) ? bus.mem_rdata_i : '0;
   assign bus.mem_en_o    = mem_en_q;
   assign bus.mem_we_o    = mem_we_q;
   assign bus.mem_addr_o  = mem_addr_q;
   assign bus.mem_wdata_o = mem_wdata_q;

`ifdef BANK_ARBITER_STATS_EN
   logic [31:0] conflict_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         conflict_cnt_q <= '0;
      end else if (($countones(eligible) >= 2) && (conflict_cnt_q != '1)) begin
         conflict_cnt_q <= conflict_cnt_q + 32'd1;
      end
   end

   assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bank_arbiter
// Directed bench for bank_arbiter: one instance owning bank 0 and one owning
// bank 1. Inputs change 1 ns after the rising edge, outputs are checked there.
// -----------------------------------------------------------------------------
module tb_bank_arbiter;
   import bank_arbiter_pkg::*;

   localparam int N  = DEFAULT_REQUESTERS;
   localparam int DW = DEFAULT_DATA_WIDTH;
   localparam int AW = DEFAULT_ADDR_WIDTH;
   localparam int BS = DEFAULT_BANK_SIZE;

   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   bank_arbiter_if if0 ();
   bank_arbiter_if if1 ();

`ifdef BANK_ARBITER_STATS_EN
   logic [31:0] cnt0;
   logic [31:0] cnt1;
`endif

   bank_arbiter #(.BANK_ID(0)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (if0)
`ifdef BANK_ARBITER_STATS_EN
      ,
      .conflict_cnt_o (cnt0)
`endif
   );

   bank_arbiter #(.BANK_ID(1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1)
`ifdef BANK_ARBITER_STATS_EN
      ,
      .conflict_cnt_o (cnt1)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      if0.req_i = '0;  if0.we_i = '0;  if0.addr_i = '0;  if0.wdata_i = '0;  if0.mem_rdata_i = '0;
      if1.req_i = '0;  if1.we_i = '0;  if1.addr_i = '0;  if1.wdata_i = '0;  if1.mem_rdata_i = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic drive_req0(input int idx, input bank_req_t r);
      if0.we_i[idx]    = r.we;
      if0.addr_i[idx]  = r.addr;
      if0.wdata_i[idx] = r.wdata;
      if0.req_i[idx]   = 1'b1;
   endtask

   // Reset dominates even with every requester active.
   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      if0.req_i = '1;
      if0.we_i  = '1;
      if0.mem_rdata_i = 17'h1FFFF;
      tick();
      tick();
      checks++; if (if0.ack_o !== 6'b0) begin errors++; $display("FAIL reset_ack: got %b expected 000000", if0.ack_o); end
      checks++; if (if0.rvalid_o !== 6'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 000000", if0.rvalid_o); end
      checks++; if (if0.rdata_o !== 17'h0) begin errors++; $display("FAIL reset_rdata: got %0h expected 0", if0.rdata_o); end
      checks++; if (if0.mem_en_o !== 1'b0 || if0.mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_mem_ctl: got en=%b we=%b expected 0 0", if0.mem_en_o, if0.mem_we_o); end
      checks++; if (if0.mem_addr_o !== 17'h0 || if0.mem_wdata_o !== 17'h0) begin errors++; $display("FAIL reset_mem_bus: got addr=%0h wdata=%0h expected 0 0", if0.mem_addr_o, if0.mem_wdata_o); end
      checks++; if (if1.ack_o !== 6'b0 || if1.mem_en_o !== 1'b0) begin errors++; $display("FAIL reset_bank1: got ack=%b en=%b expected 0", if1.ack_o, if1.mem_en_o); end
`ifdef BANK_ARBITER_STATS_EN
      checks++; if (cnt0 !== 32'd0) begin errors++; $display("FAIL reset_conflict_cnt: got %0d expected 0", cnt0); end
`endif
      clear_inputs();
      rst = 1'b0;
   endtask

   // Requester 0 writes 0x1A5 to address 5 of bank 0.
   task automatic test_write();
      bank_req_t r;
      do_reset();
      r.we = 1'b1;
      r.addr = 17'd5;
      r.wdata = 17'h1A5;
      drive_req0(0, r);
      tick();
      checks++; if (if0.ack_o !== 6'b000001) begin errors++; $display("FAIL write_ack: got %b expected 000001", if0.ack_o); end
      checks++; if (if0.mem_en_o !== 1'b1 || if0.mem_we_o !== 1'b1) begin errors++; $display("FAIL write_mem_ctl: got en=%b we=%b expected 1 1", if0.mem_en_o, if0.mem_we_o); end
      checks++; if (if0.mem_addr_o !== 17'd5) begin errors++; $display("FAIL write_addr: got %0h expected 5", if0.mem_addr_o); end
      checks++; if (if0.mem_wdata_o !== 17'h1A5) begin errors++; $display("FAIL write_wdata: got %0h expected 1a5", if0.mem_wdata_o); end
      checks++; if (if0.rvalid_o !== 6'b0) begin errors++; $display("FAIL write_rvalid_n1: got %b expected 000000", if0.rvalid_o); end
      if0.req_i = '0;
      tick();
      checks++; if (if0.rvalid_o !== 6'b0 || if0.rdata_o !== 17'h0) begin errors++; $display("FAIL write_rvalid_n2: got %b/%0h expected 000000/0", if0.rvalid_o, if0.rdata_o); end
      checks++; if (if0.ack_o !== 6'b0 || if0.mem_en_o !== 1'b0) begin errors++; $display("FAIL write_idle: got ack=%b en=%b expected 0", if0.ack_o, if0.mem_en_o); end
   endtask

   // Bank 1 instance: requester 2 reads global address BANK_SIZE+3.
   task automatic test_bank1_read();
      do_reset();
      if1.mem_rdata_i = 17'h0F0F;
      if1.we_i[2]   = 1'b0;
      if1.addr_i[2] = AW'(BS + 3);
      if1.req_i[2]  = 1'b1;
      tick();
      checks++; if (if1.ack_o !== 6'b000100) begin errors++; $display("FAIL b1_ack: got %b expected 000100", if1.ack_o); end
      checks++; if (if1.mem_addr_o !== 17'd3) begin errors++; $display("FAIL b1_addr: got %0h expected 3", if1.mem_addr_o); end
      checks++; if (if1.mem_en_o !== 1'b1 || if1.mem_we_o !== 1'b0) begin errors++; $display("FAIL b1_mem_ctl: got en=%b we=%b expected 1 0", if1.mem_en_o, if1.mem_we_o); end
      checks++; if (if1.rvalid_o !== 6'b0) begin errors++; $display("FAIL b1_rvalid_n1: got %b expected 000000", if1.rvalid_o); end
      if1.req_i = '0;
      tick();
      checks++; if (if1.rvalid_o !== 6'b000100) begin errors++; $display("FAIL b1_rvalid_n2: got %b expected 000100", if1.rvalid_o); end
      checks++; if (if1.rdata_o !== 17'h0F0F) begin errors++; $display("FAIL b1_rdata: got %0h expected f0f", if1.rdata_o); end
      tick();
      checks++; if (if1.rvalid_o !== 6'b0 || if1.rdata_o !== 17'h0) begin errors++; $display("FAIL b1_rdata_idle: got %b/%0h expected 000000/0", if1.rvalid_o, if1.rdata_o); end
   endtask

   // All six requesters hold reads for 12 grant cycles.
   task automatic test_back_to_back();
      int            ack_cnt [N];
      logic [N-1:0]  exp_ack;
      logic [N-1:0]  exp_rv;
      logic [DW-1:0] exp_rd;
      do_reset();
      for (int i = 0; i < N; i++) begin
         ack_cnt[i] = 0;
         if0.addr_i[i] = AW'(i * 4 + 100);
      end
      if0.mem_rdata_i = 17'h0ABC;
      if0.req_i = '1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         exp_ack = N'(1) << ((k - 1) % N);
         exp_rv  = (k >= 2) ? (N'(1) << ((k - 2) % N)) : '0;
         exp_rd  = (k >= 2) ? 17'h0ABC : 17'h0;
         checks++; if (if0.ack_o !== exp_ack) begin errors++; $display("FAIL b2b_ack[%0d]: got %b expected %b", k, if0.ack_o, exp_ack); end
         checks++; if (if0.rvalid_o !== exp_rv || if0.rdata_o !== exp_rd) begin errors++; $display("FAIL b2b_rvalid[%0d]: got %b/%0h expected %b/%0h", k, if0.rvalid_o, if0.rdata_o, exp_rv, exp_rd); end
         for (int i = 0; i < N; i++) begin
            if (if0.ack_o[i]) ack_cnt[i]++;
         end
         if (k == 12) if0.req_i = '0;
      end
      for (int i = 0; i < N; i++) begin
         checks++; if (ack_cnt[i] !== 2) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected 2", i, ack_cnt[i]); end
      end
      tick();
      checks++; if (if0.ack_o !== 6'b0) begin errors++; $display("FAIL b2b_tail_ack: got %b expected 000000", if0.ack_o); end
      checks++; if (if0.rvalid_o !== 6'b100000) begin errors++; $display("FAIL b2b_tail_rvalid: got %b expected 100000", if0.rvalid_o); end
   endtask

   // Requester 3 targets bank 1 for 20 cycles; bank 0 must ignore it.
   task automatic test_out_of_range();
      do_reset();
      if0.addr_i[3] = AW'(BS + 7);
      if0.req_i[3]  = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         checks++; if (if0.ack_o[3] !== 1'b0 || if0.mem_en_o !== 1'b0) begin errors++; $display("FAIL oor[%0d]: got ack3=%b en=%b expected 0 0", k, if0.ack_o[3], if0.mem_en_o); end
      end
      if0.req_i = '0;
   endtask

   // Reset raised in the cycle after a read grant drops the read.
   task automatic test_reset_mid_read();
      do_reset();
      if0.mem_rdata_i = 17'h1234;
      if0.addr_i[1] = 17'd9;
      if0.req_i[1]  = 1'b1;
      tick();
      checks++; if (if0.ack_o !== 6'b000010) begin errors++; $display("FAIL rmid_ack: got %b expected 000010", if0.ack_o); end
      rst = 1'b1;
      if0.req_i = '0;
      tick();
      checks++; if (if0.rvalid_o !== 6'b0 || if0.rdata_o !== 17'h0) begin errors++; $display("FAIL rmid_rvalid: got %b/%0h expected 000000/0", if0.rvalid_o, if0.rdata_o); end
      checks++; if (if0.ack_o !== 6'b0 || if0.mem_en_o !== 1'b0 || if0.mem_we_o !== 1'b0) begin errors++; $display("FAIL rmid_ctl: got ack=%b en=%b we=%b expected 0", if0.ack_o, if0.mem_en_o, if0.mem_we_o); end
      checks++; if (if0.mem_addr_o !== 17'h0 || if0.mem_wdata_o !== 17'h0) begin errors++; $display("FAIL rmid_bus: got addr=%0h wdata=%0h expected 0 0", if0.mem_addr_o, if0.mem_wdata_o); end
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (if0.rvalid_o !== 6'b0 || if0.rdata_o !== 17'h0) begin errors++; $display("FAIL rmid_after[%0d]: got %b/%0h expected 000000/0", k, if0.rvalid_o, if0.rdata_o); end
      end
   endtask

`ifdef BANK_ARBITER_STATS_EN
   // Three requesters held for 4 cycles: each cycle at least two are eligible.
   task automatic test_stats();
      do_reset();
      if0.addr_i[0] = 17'd1;
      if0.addr_i[1] = 17'd2;
      if0.addr_i[2] = 17'd3;
      if0.req_i = 6'b000111;
      for (int k = 0; k < 4; k++) tick();
      if0.req_i = '0;
      checks++; if (cnt0 !== 32'd4) begin errors++; $display("FAIL stats_cnt: got %0d expected 4", cnt0); end
      tick();
      checks++; if (cnt0 !== 32'd4) begin errors++; $display("FAIL stats_hold: got %0d expected 4", cnt0); end
   endtask
`endif

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_write();
      test_bank1_read();
      test_back_to_back();
      test_out_of_range();
      test_reset_mid_read();
`ifdef BANK_ARBITER_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
